regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_if.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the requesters (core writeback, debug host, clear trigger)
// and regfile_write_arbiter, plus the register-file write port it drives.
interface regfile_write_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 24
);
  logic              CoreWrValid;
  logic [ADDR_W-1:0] CoreWrAddr;
  logic [DATA_W-1:0] CoreWrData;
  logic              CoreWrReady;
  logic              DbgWrValid;
  logic [ADDR_W-1:0] DbgWrAddr;
  logic [DATA_W-1:0] DbgWrData;
  logic              DbgWrReady;
  logic              ClearStart;
  logic              ClearBusy;
  logic              ClearDone;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;

  modport master (
    output CoreWrValid, CoreWrAddr, CoreWrData,
    output DbgWrValid, DbgWrAddr, DbgWrData,
    output ClearStart,
    input  CoreWrReady, DbgWrReady, ClearBusy, ClearDone,
    input  RD, WriteData, RegWrite
  );

  modport slave (
    input  CoreWrValid, CoreWrAddr, CoreWrData,
    input  DbgWrValid, DbgWrAddr, DbgWrData,
    input  ClearStart,
    output CoreWrReady, DbgWrReady, ClearBusy, ClearDone,
    output RD, WriteData, RegWrite
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port (core writeback vs debug writes).
// Defining REGFILE_CLEAR_EN adds a sequencer that zeroes every register on ClearStart.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned NUM_REGS = 16
) (
  input logic                    Clock,
  input logic                    Reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic              last_dbg;
  logic              clear_req;
  logic              core_ready;
  logic              dbg_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              reg_write_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] write_data_q;

`ifdef REGFILE_CLEAR_EN
  localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);

  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             clear_busy_q;
  logic             clear_done_q;

  // State register and clear address counter
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Beat 0 is issued from IDLE, so the counter enters CLEAR already pointing at register 1;
  // the final CLEAR cycle (cnt == NUM_REGS) issues nothing and only hands back to IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (bus.ClearStart) begin
          state_next = CLEAR;
          cnt_next   = CNT_W'(1);
        end
      end
      CLEAR: begin
        if (cnt == CNT_W'(NUM_REGS)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      clear_busy_q <= (state_next == CLEAR);
      clear_done_q <= (state == CLEAR) && (state_next == IDLE);
    end
  end

  assign clear_req     = bus.ClearStart;
  assign bus.ClearBusy = clear_busy_q;
  assign bus.ClearDone = clear_done_q;
`else
  assign state         = IDLE;
  assign clear_req     = 1'b0;
  assign bus.ClearBusy = 1'b0;
  assign bus.ClearDone = 1'b0;
`endif

  // Grant and write-beat selection; nothing is granted while Reset is asserted
  always_comb begin
    core_ready = 1'b0;
    dbg_ready  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    if (!Reset) begin
      if (state == IDLE) begin
        if (clear_req) begin
          wr_en = 1'b1;
        end else if (bus.CoreWrValid && (!bus.DbgWrValid || last_dbg)) begin
          core_ready = 1'b1;
          wr_en      = 1'b1;
          wr_addr    = bus.CoreWrAddr;
          wr_data    = bus.CoreWrData;
        end else if (bus.DbgWrValid) begin
          dbg_ready = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = bus.DbgWrAddr;
          wr_data   = bus.DbgWrData;
        end
      end
`ifdef REGFILE_CLEAR_EN
      else if (cnt != CNT_W'(NUM_REGS)) begin
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(cnt);
      end
`endif
    end
  end

  // Write port register; address and data hold between beats
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      last_dbg     <= 1'b1;
    end else begin
      reg_write_q <= wr_en;
      if (wr_en) begin
        rd_q         <= wr_addr;
        write_data_q <= wr_data;
      end
      if (core_ready) begin
        last_dbg <= 1'b0;
      end else if (dbg_ready) begin
        last_dbg <= 1'b1;
      end
    end
  end

  assign bus.CoreWrReady = core_ready;
  assign bus.DbgWrReady  = dbg_ready;
  assign bus.RegWrite    = reg_write_q;
  assign bus.RD          = rd_q;
  assign bus.WriteData   = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: accepted transfers and clear beats queue
// expected writes, a negedge monitor pops and compares them against the write port.
module tb_regfile_write_arbiter;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned NUM_REGS = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } wr_t;

  logic Clock = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   base;
  int   done_snap;
  wr_t  exp_q[$];
  wr_t  e_m;

  regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_write_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_clear(input int start_cyc);
    for (int k = 0; k < int'(NUM_REGS); k++)
      exp_q.push_back('{ADDR_W'(k), DATA_W'(0), start_cyc + 1 + k});
  endtask

  // Write-port monitor and transfer capture
  always @(negedge Clock) begin
    if (!Reset) begin
      if (bus.RegWrite) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(exp_q.size()), 32'd1);
        end else begin
          e_m = exp_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(e_m.cyc));
          check("wr_rd", 32'(bus.RD), 32'(e_m.addr));
          check("wr_data", 32'(bus.WriteData), 32'(e_m.data));
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check("missed_write", 32'(bus.RegWrite), 32'd1);
        void'(exp_q.pop_front());
      end
      check("ready_exclusive", 32'(bus.CoreWrReady & bus.DbgWrReady), 32'd0);
      if (bus.CoreWrValid && bus.CoreWrReady)
        exp_q.push_back('{bus.CoreWrAddr, bus.CoreWrData, cyc + 1});
      if (bus.DbgWrValid && bus.DbgWrReady)
        exp_q.push_back('{bus.DbgWrAddr, bus.DbgWrData, cyc + 1});
      if (bus.ClearDone) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset           = 1'b1;
    bus.CoreWrValid = 1'b1;
    bus.CoreWrAddr  = '0;
    bus.CoreWrData  = '0;
    bus.DbgWrValid  = 1'b0;
    bus.DbgWrAddr   = '0;
    bus.DbgWrData   = '0;
    bus.ClearStart  = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_rd", 32'(bus.RD), 32'd0);
    check("rst_wdata", 32'(bus.WriteData), 32'd0);
    check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("rst_busy", 32'(bus.ClearBusy), 32'd0);
    check("rst_done", 32'(bus.ClearDone), 32'd0);
    check("rst_core_ready", 32'(bus.CoreWrReady), 32'd0);
    tick();
    bus.CoreWrValid = 1'b0;
    Reset           = 1'b0;
    tick();

    // Conflict right after reset: core first, then debug
    bus.CoreWrValid = 1'b1; bus.CoreWrAddr = 4'd1; bus.CoreWrData = 24'h000011;
    bus.DbgWrValid  = 1'b1; bus.DbgWrAddr  = 4'd2; bus.DbgWrData  = 24'h000022;
    @(negedge Clock);
    check("cf1_core_ready", 32'(bus.CoreWrReady), 32'd1);
    check("cf1_dbg_ready", 32'(bus.DbgWrReady), 32'd0);
    tick();
    bus.CoreWrValid = 1'b0;
    @(negedge Clock);
    check("cf2_dbg_ready", 32'(bus.DbgWrReady), 32'd1);
    check("cf2_core_ready", 32'(bus.CoreWrReady), 32'd0);
    tick();
    bus.DbgWrValid = 1'b0;
    repeat (3) tick();

    // Core-only write
    bus.CoreWrValid = 1'b1; bus.CoreWrAddr = 4'd3; bus.CoreWrData = 24'hABCDEF;
    @(negedge Clock);
    check("core_ready", 32'(bus.CoreWrReady), 32'd1);
    tick();
    bus.CoreWrValid = 1'b0;
    @(negedge Clock);
    check("core_rd", 32'(bus.RD), 32'd3);
    tick();
    @(negedge Clock);
    check("core_regwrite_drop", 32'(bus.RegWrite), 32'd0);
    tick();

    // Back-to-back debug writes
    bus.DbgWrValid = 1'b1; bus.DbgWrAddr = 4'd15; bus.DbgWrData = 24'hFFFFFF;
    @(negedge Clock);
    check("b2b1_dbg_ready", 32'(bus.DbgWrReady), 32'd1);
    tick();
    bus.DbgWrData = 24'h000001;
    @(negedge Clock);
    check("b2b2_dbg_ready", 32'(bus.DbgWrReady), 32'd1);
    tick();
    bus.DbgWrValid = 1'b0;
    repeat (3) tick();

`ifdef REGFILE_CLEAR_EN
    // Clear sequence with a core request pending
    bus.CoreWrValid = 1'b1; bus.CoreWrAddr = 4'd5; bus.CoreWrData = 24'h123456;
    bus.ClearStart  = 1'b1;
    base = cyc;
    push_clear(base);
    done_snap = done_cnt;
    @(negedge Clock);
    check("clr_start_core_ready", 32'(bus.CoreWrReady), 32'd0);
    check("clr_start_busy", 32'(bus.ClearBusy), 32'd0);
    tick();
    bus.ClearStart = 1'b0;
    for (int i = 1; i <= int'(NUM_REGS); i++) begin
      @(negedge Clock);
      check("clr_core_ready", 32'(bus.CoreWrReady), 32'd0);
      check("clr_busy", 32'(bus.ClearBusy), 32'd1);
      check("clr_done_early", 32'(bus.ClearDone), 32'd0);
      tick();
    end
    @(negedge Clock);
    check("clr_done", 32'(bus.ClearDone), 32'd1);
    check("clr_end_busy", 32'(bus.ClearBusy), 32'd0);
    check("clr_end_core_ready", 32'(bus.CoreWrReady), 32'd1);
    tick();
    bus.CoreWrValid = 1'b0;
    @(negedge Clock);
    check("clr_done_pulse", 32'(bus.ClearDone), 32'd0);
    check("clr_done_count", 32'(done_cnt - done_snap), 32'd1);
    repeat (3) tick();

    // Reset in the middle of a clear
    bus.ClearStart = 1'b1;
    push_clear(cyc);
    tick();
    bus.ClearStart = 1'b0;
    repeat (7) tick();
    check("mid_rd7", 32'(bus.RD), 32'd7);
    check("mid_regwrite", 32'(bus.RegWrite), 32'd1);
    Reset = 1'b1;
    #1;
    check("mid_rst_rd", 32'(bus.RD), 32'd0);
    check("mid_rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("mid_rst_busy", 32'(bus.ClearBusy), 32'd0);
    check("mid_rst_wdata", 32'(bus.WriteData), 32'd0);
    exp_q.delete();
    done_snap = done_cnt;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      check("post_rst_busy", 32'(bus.ClearBusy), 32'd0);
      tick();
    end
    check("post_rst_no_done", 32'(done_cnt - done_snap), 32'd0);
    bus.CoreWrValid = 1'b1; bus.CoreWrAddr = 4'd9; bus.CoreWrData = 24'h00BEEF;
    @(negedge Clock);
    check("post_rst_core_ready", 32'(bus.CoreWrReady), 32'd1);
    tick();
    bus.CoreWrValid = 1'b0;
    repeat (3) tick();
`else
    // ClearStart has no effect without the clear sequencer
    bus.CoreWrValid = 1'b1; bus.CoreWrAddr = 4'd4; bus.CoreWrData = 24'h0F0F0F;
    bus.ClearStart  = 1'b1;
    @(negedge Clock);
    check("noclr_core_ready", 32'(bus.CoreWrReady), 32'd1);
    tick();
    bus.CoreWrValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("noclr_busy", 32'(bus.ClearBusy), 32'd0);
      check("noclr_done", 32'(bus.ClearDone), 32'd0);
      tick();
    end
    bus.ClearStart = 1'b0;
    repeat (2) tick();
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
